// File: rtl/vx_fixed_lat_sched.sv
// Issue scheduler for a shared fixed-latency execution pipe.
// Round-robin arbitrates NUM_REQS requesters onto one external pipe whose
// result appears DEPTH cycles after issue. A {valid, tag} delay line tracks
// in-flight work, and completed results land in an output FIFO. Issue is
// credit-gated against that FIFO, so the pipe never needs a stall input.
//
// Handshakes: a request transfers in a cycle where req_valid[i] and
// req_ready[i] are both high (req_ready is one-hot or zero, combinational
// on req_valid); a response transfers in a cycle where rsp_valid and
// rsp_ready are both high. exe_valid is a pure strobe and has no ready.
module vx_fixed_lat_sched #(
  parameter int NUM_REQS  = 4,
  parameter int DATAW     = 32,
  parameter int DEPTH     = 4,
  parameter int OBUF_SIZE = 4,
  parameter int TAGW      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      exe_valid,
  output logic [DATAW-1:0]          exe_data,
  input  logic [DATAW-1:0]          exe_result,
  output logic                      rsp_valid,
  output logic [DATAW-1:0]          rsp_data,
  output logic [TAGW-1:0]           rsp_tag,
  input  logic                      rsp_ready
);

  localparam int CNTW = $clog2(OBUF_SIZE + 1);
  localparam int PTRW = (OBUF_SIZE > 1) ? $clog2(OBUF_SIZE) : 1;

  // Credit counter, round-robin pointer
  logic [CNTW-1:0]  r_cnt;
  logic [TAGW-1:0]  r_rr;

  // Tracking line
  logic             r_trk_vld [DEPTH];
  logic [TAGW-1:0]  r_trk_tag [DEPTH];

  // Output FIFO
  logic [DATAW-1:0] r_mem_data [OBUF_SIZE];
  logic [TAGW-1:0]  r_mem_tag  [OBUF_SIZE];
  logic [PTRW-1:0]  r_wptr;
  logic [PTRW-1:0]  r_rptr;
  logic [CNTW-1:0]  r_occ;

  logic             w_can_issue;
  logic             w_issue;
  logic             w_rsp_fire;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_hi_found;
  logic             w_lo_found;
  logic [TAGW-1:0]  w_hi_idx;
  logic [TAGW-1:0]  w_lo_idx;
  logic [TAGW-1:0]  w_gnt;

  // Issue is held off during reset so nothing enters the pipe while state clears.
  assign w_can_issue = !reset && (r_cnt < CNTW'(OBUF_SIZE));
  assign w_issue     = w_can_issue && (|req_valid);
  assign exe_valid   = w_issue;

  assign rsp_valid   = (r_occ != '0);
  assign w_rsp_fire  = rsp_valid && rsp_ready;
  assign w_pop       = w_rsp_fire;
  assign w_push      = r_trk_vld[DEPTH-1];
  assign w_full      = (r_occ == CNTW'(OBUF_SIZE));
  assign rsp_data    = r_mem_data[r_rptr];
  assign rsp_tag     = r_mem_tag[r_rptr];

  // Round-robin pick: lowest valid index at/above rr, else lowest valid below rr.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (i >= int'(r_rr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = TAGW'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo_idx   = TAGW'(i);
        end
      end
    end
    w_gnt = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  // Ready to the granted requester and operand mux to the pipe.
  always_comb begin
    req_ready = '0;
    exe_data  = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (w_gnt == TAGW'(i)) begin
        req_ready[i] = w_issue;
        exe_data     = req_data[i*DATAW +: DATAW];
      end
    end
  end

  // Credits: ops in flight plus buffered results; issue and pop together cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_issue && !w_rsp_fire) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (!w_issue && w_rsp_fire) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Pointer advances past the winner on issue only; no lock is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr <= '0;
    end else if (w_issue) begin
      r_rr <= (w_gnt == TAGW'(NUM_REQS - 1)) ? '0 : w_gnt + 1'b1;
    end
  end

  // Valid half of the tracking line shifts every cycle; reset drops in-flight ops.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_trk_vld[i] <= 1'b0;
    end else begin
      r_trk_vld[0] <= w_issue;
      for (int i = 1; i < DEPTH; i++) r_trk_vld[i] <= r_trk_vld[i-1];
    end
  end

  // Tag half of the tracking line; only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    r_trk_tag[0] <= w_gnt;
    for (int i = 1; i < DEPTH; i++) r_trk_tag[i] <= r_trk_tag[i-1];
  end

  // FIFO storage: capture the pipe result with its tag when the tail is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= exe_result;
      r_mem_tag[r_wptr]  <= r_trk_tag[DEPTH-1];
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop is legal at any level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PTRW'(OBUF_SIZE - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PTRW'(OBUF_SIZE - 1)) ? '0 : r_rptr + 1'b1;
      if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
      else if (!w_push && w_pop) r_occ <= r_occ - 1'b1;
    end
  end

  // Credit gating must make an unpopped push into a full buffer impossible.
  assert property (@(posedge clk) disable iff (reset) !(w_push && w_full && !w_pop));

endmodule

// File: tb/tb_vx_fixed_lat_sched.sv
// Bench for vx_fixed_lat_sched: a transaction-level model (credits as queue
// sizes, in-flight ops as timestamped records) checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_vx_fixed_lat_sched;
  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int OBUF  = 4;
  localparam int TAGW  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic [N-1:0]    req_ready;
  logic            exe_valid;
  logic [DW-1:0]   exe_data;
  logic [DW-1:0]   exe_result;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_ready = 1'b0;

  vx_fixed_lat_sched #(
    .NUM_REQS(N), .DATAW(DW), .DEPTH(DEPTH), .OBUF_SIZE(OBUF)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .exe_valid(exe_valid), .exe_data(exe_data), .exe_result(exe_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready)
  );

  // External pipe: result = operand + 1, exactly DEPTH cycles later, never reset.
  logic [DW-1:0] pipe [DEPTH];
  always @(posedge clk) begin
    pipe[0] <= exe_valid ? exe_data + 32'd1 : 32'hDEADBEEF;
    for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
  end
  assign exe_result = pipe[DEPTH-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int              due;
    logic [TAGW-1:0] tag;
    logic [DW-1:0]   res;
  } fl_t;

  fl_t             inflight[$];
  logic [DW-1:0]   exp_q[$];
  logic [TAGW-1:0] exp_tag_q[$];
  int              m_rr;
  int              m_credit;
  int              m_g;
  bit              m_issue;
  fl_t             m_e;

  // Observation logs from the model, used by the literal checks.
  int            gnt_log[$];
  int            gnt_cyc[$];
  int            rsp_tag_log[$];
  logic [DW-1:0] rsp_data_log[$];
  int            pop_cyc[$];

  // Compare process: evaluate the model for this cycle, check, then advance it.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_exe_valid", exe_valid, 0);
      inflight.delete();
      exp_q.delete();
      exp_tag_q.delete();
      m_rr = 0;
    end else begin
      m_credit = inflight.size() + exp_q.size();
      m_issue  = (m_credit < OBUF) && (req_valid != '0);
      m_g      = 0;
      if (m_issue)
        for (int k = N - 1; k >= 0; k--)
          if (req_valid[(m_rr + k) % N]) m_g = (m_rr + k) % N;

      chk("req_ready", req_ready, m_issue ? (64'd1 << m_g) : 64'd0);
      chk("exe_valid", exe_valid, m_issue);
      if (m_issue) chk("exe_data", exe_data, req_data[m_g*DW +: DW]);
      chk("rsp_valid", rsp_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        chk("rsp_data", rsp_data, exp_q[0]);
        chk("rsp_tag", rsp_tag, exp_tag_q[0]);
      end

      if (exp_q.size() > 0 && rsp_ready) begin
        rsp_tag_log.push_back(int'(exp_tag_q[0]));
        rsp_data_log.push_back(exp_q[0]);
        pop_cyc.push_back(cyc);
        void'(exp_q.pop_front());
        void'(exp_tag_q.pop_front());
      end
      if (inflight.size() > 0 && inflight[0].due == cyc) begin
        exp_q.push_back(inflight[0].res);
        exp_tag_q.push_back(inflight[0].tag);
        void'(inflight.pop_front());
      end
      if (exp_q.size() > OBUF) chk("model_obuf_overflow", exp_q.size(), OBUF);
      if (m_issue) begin
        m_e.due = cyc + DEPTH;
        m_e.tag = m_g[TAGW-1:0];
        m_e.res = req_data[m_g*DW +: DW] + 32'd1;
        inflight.push_back(m_e);
        gnt_log.push_back(m_g);
        gnt_cyc.push_back(cyc);
        m_rr = (m_g + 1) % N;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  task automatic drain();
    int k;
    k = 0;
    rsp_ready = 1'b1;
    while ((inflight.size() != 0 || exp_q.size() != 0) && k < 60) begin
      step();
      k++;
    end
    chk("drain_in_budget", k < 60, 1);
  endtask

  task automatic wait_rsp(input string name, input int exp_lat);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rsp_valid && k < 20);
    chk(name, k, exp_lat);
  endtask

  task automatic wait_grants(input int target);
    int k;
    k = 0;
    while (gnt_log.size() < target && k < 50) begin
      step();
      k++;
    end
    chk("grants_in_budget", gnt_log.size() >= target, 1);
  endtask

  // ---------------- directed stimulus ----------------
  int base, rbase, pbase;
  int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_icyc  [8] = '{0, 1, 2, 3, 6, 7, 8, 9};
  int exp_skip  [4] = '{3, 0, 3, 0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    step();
    step();

    // Single requester: grant in cycle 0, response in cycle 5.
    do_reset();
    @(negedge clk);
    chk("t1_rsp_valid_after_reset", rsp_valid, 0);
    step();
    rsp_ready = 1'b1;
    set_data(2, 32'h11);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t1_req_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    wait_rsp("t1_latency", 5);
    chk("t1_rsp_data", rsp_data, 32'h12);
    chk("t1_rsp_tag", rsp_tag, 2);
    drain();

    // Fairness: all requesters valid for 8 issues.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, 32'h100 * (i + 1));
    req_valid = 4'hF;
    base  = gnt_log.size();
    rbase = rsp_tag_log.size();
    wait_grants(base + 8);
    req_valid = '0;
    drain();
    chk("t2_rsp_count", rsp_tag_log.size() - rbase, 8);
    if (gnt_log.size() >= base + 8 && rsp_tag_log.size() >= rbase + 8)
      for (int j = 0; j < 8; j++) begin
        chk("t2_grant_order", gnt_log[base+j], exp_order[j]);
        chk("t2_issue_cycle", gnt_cyc[base+j] - gnt_cyc[base], exp_icyc[j]);
        chk("t2_rsp_order", rsp_tag_log[rbase+j], exp_order[j]);
      end

    // Backpressure: 4 issues then stall; one pop frees exactly one issue.
    do_reset();
    rsp_ready = 1'b0;
    set_data(0, 32'h200);
    req_valid = 4'b0001;
    base  = gnt_log.size();
    pbase = pop_cyc.size();
    repeat (12) step();
    chk("t3_issues_stalled", gnt_log.size() - base, 4);
    @(negedge clk);
    chk("t3_ready_low", req_ready, 0);
    step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    repeat (10) step();
    chk("t3_pops", pop_cyc.size() - pbase, 1);
    chk("t3_issues_after_pop", gnt_log.size() - base, 5);
    if (gnt_log.size() >= base + 5 && pop_cyc.size() >= pbase + 1)
      chk("t3_resume_delay", gnt_cyc[base+4] - pop_cyc[pbase], 1);
    req_valid = '0;
    drain();

    // Push and pop in the same cycle with 3 buffered and 1 arriving.
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    pbase = pop_cyc.size();
    for (int j = 0; j < 4; j++) begin
      set_data(0, 32'hA0 + j);
      step();
    end
    req_valid = '0;
    repeat (3) step();
    chk("t4_occ_before", exp_q.size(), 3);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t4_occ_after", exp_q.size(), 3);
    drain();
    chk("t4_pop_count", pop_cyc.size() - pbase, 4);
    if (rsp_data_log.size() >= pbase + 4)
      for (int j = 0; j < 4; j++) chk("t4_data", rsp_data_log[pbase+j], 32'hA1 + j);

    // Reset mid-flight: old issues vanish, new issue has normal latency.
    do_reset();
    rsp_ready = 1'b1;
    set_data(0, 32'h300);
    set_data(1, 32'h301);
    set_data(2, 32'h302);
    req_valid = 4'b0111;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_valid = '0;
    rbase = rsp_tag_log.size();
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("t5_no_stale_rsp", rsp_valid, 0);
      step();
    end
    set_data(0, 32'h55);
    req_valid = 4'b0011;
    @(negedge clk);
    chk("t5_req_ready_rr_reset", req_ready, 4'b0001);
    step();
    req_valid = '0;
    wait_rsp("t5_latency", 5);
    chk("t5_rsp_data", rsp_data, 32'h56);
    chk("t5_rsp_tag", rsp_tag, 0);
    drain();
    chk("t5_rsp_count", rsp_tag_log.size() - rbase, 1);

    // Skipped requesters: rr at 1, valid 4'b1001.
    do_reset();
    rsp_ready = 1'b1;
    set_data(0, 32'h400);
    set_data(3, 32'h403);
    req_valid = 4'b0001;
    step();
    req_valid = 4'b1001;
    base = gnt_log.size();
    wait_grants(base + 4);
    req_valid = '0;
    drain();
    if (gnt_log.size() >= base + 4)
      for (int j = 0; j < 4; j++) chk("t6_grant_order", gnt_log[base+j], exp_skip[j]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
